// File: rtl/bottle_dozen_sequencer_pkg.sv
// Shared definitions for the bottle/dozen sequencer: FSM state encodings,
// default batch/dozen limits and the full-adder helper used by sum4bit.
package bottle_dozen_sequencer_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE       = 2'd0,
        SEQ_ADD_BOTTLE = 2'd1,
        SEQ_ADD_DOZEN  = 2'd2
    } seq_state_e;

    localparam int unsigned SEQ_BATCH_SIZE_DEF = 32'd12;
    localparam int unsigned SEQ_DOZEN_MAX_DEF  = 32'd9;

    // One-bit full adder, returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
        return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
    endfunction

endpackage

// File: rtl/bottle_dozen_sequencer_sum4bit.sv
// Four-bit ripple-carry adder shared by the bottle and dozen increment passes.
module sum4bit
    import bottle_dozen_sequencer_pkg::*;
(
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c,
    output logic [3:0] o_s,
    output logic       o_cout
);

    logic [4:0] w_carry;
    logic [3:0] w_sum;

    // Ripple the carry through four full-adder stages.
    always_comb begin
        w_carry    = 5'b00000;
        w_sum      = 4'b0000;
        w_carry[0] = i_c;
        for (int i = 0; i < 4; i++) begin
            {w_carry[i+1], w_sum[i]} = full_add(i_a[i], i_b[i], w_carry[i]);
        end
    end

    assign o_s    = w_sum;
    assign o_cout = w_carry[4];

endmodule

// File: rtl/bottle_dozen_sequencer.sv
// Counts bottles and completed batches with one shared 4-bit adder.
// Build option: define SEQ_DOZEN_SAT_EN to saturate dozen_cnt at DOZEN_MAX instead of wrapping.
module bottle_dozen_sequencer
    import bottle_dozen_sequencer_pkg::*;
#(
    parameter int unsigned BATCH_SIZE = SEQ_BATCH_SIZE_DEF,
    parameter int unsigned DOZEN_MAX  = SEQ_DOZEN_MAX_DEF
)
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_bottle_done,
    input  logic       i_clear,
    output logic [3:0] o_bottle_cnt,
    output logic [3:0] o_dozen_cnt,
    output logic       o_dozen_pulse,
    output logic       o_busy,
    output logic       o_overrun,
    output logic       o_full
);

    localparam logic [3:0] LP_BATCH     = BATCH_SIZE[3:0];
    localparam logic [3:0] LP_DOZEN_MAX = DOZEN_MAX[3:0];

    seq_state_e r_state;
    logic [3:0] r_bottle_cnt;
    logic [3:0] r_dozen_cnt;
    logic       r_dozen_pulse;
    logic       r_overrun;
    logic       r_pending;
    logic       r_prev_done;

    seq_state_e w_state_nxt;
    logic [3:0] w_bottle_nxt;
    logic [3:0] w_dozen_nxt;
    logic       w_pulse_nxt;
    logic       w_overrun_nxt;
    logic       w_pending_nxt;

    logic       w_evt;
    logic       w_busy;
    logic       w_full;
    logic       w_evt_hold;
    logic       w_evt_lost;
    logic [3:0] w_add_a;
    logic [3:0] w_sum;
    logic       w_cout;

    assign w_evt      = i_bottle_done & ~r_prev_done;
    assign w_busy     = (r_state != SEQ_IDLE);
    assign w_full     = (r_dozen_cnt == LP_DOZEN_MAX);
    assign w_evt_hold = w_busy & w_evt & ~r_pending;
    assign w_evt_lost = w_busy & w_evt & r_pending;
    assign w_add_a    = (r_state == SEQ_ADD_DOZEN) ? r_dozen_cnt : r_bottle_cnt;

    // Increment comes from carry-in; B is tied to zero.
    sum4bit u_sum4bit (
        .i_a    (w_add_a),
        .i_b    (4'b0000),
        .i_c    (1'b1),
        .o_s    (w_sum),
        .o_cout (w_cout)
    );

    // Next-state and next-value logic for the sequencer.
    always_comb begin
        w_state_nxt   = r_state;
        w_bottle_nxt  = r_bottle_cnt;
        w_dozen_nxt   = r_dozen_cnt;
        w_pulse_nxt   = 1'b0;
        w_overrun_nxt = r_overrun | w_evt_lost;
        w_pending_nxt = r_pending | w_evt_hold;
        case (r_state)
            SEQ_IDLE: begin
                if (w_evt || r_pending) begin
                    w_state_nxt   = SEQ_ADD_BOTTLE;
                    // A fresh edge alongside a queued one re-arms the slot.
                    w_pending_nxt = w_evt & r_pending;
                end else begin
                    w_state_nxt   = SEQ_IDLE;
                end
            end
            SEQ_ADD_BOTTLE: begin
                if ((w_sum == LP_BATCH) || w_cout) begin
                    w_bottle_nxt = 4'd0;
                    w_state_nxt  = SEQ_ADD_DOZEN;
                end else begin
                    w_bottle_nxt = w_sum;
                    w_state_nxt  = SEQ_IDLE;
                end
            end
            SEQ_ADD_DOZEN: begin
                w_state_nxt = SEQ_IDLE;
`ifdef SEQ_DOZEN_SAT_EN
                if (w_full) begin
                    w_overrun_nxt = 1'b1;
                end else begin
                    w_dozen_nxt = w_sum;
                    w_pulse_nxt = 1'b1;
                end
`else
                if (w_full) begin
                    w_dozen_nxt = 4'd0;
                end else begin
                    w_dozen_nxt = w_sum;
                end
                w_pulse_nxt = 1'b1;
`endif
            end
            default: begin
                w_state_nxt = SEQ_IDLE;
            end
        endcase
    end

    // State and counter registers; clear aborts any sequence in flight.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= SEQ_IDLE;
            r_bottle_cnt  <= 4'd0;
            r_dozen_cnt   <= 4'd0;
            r_dozen_pulse <= 1'b0;
            r_overrun     <= 1'b0;
            r_pending     <= 1'b0;
            r_prev_done   <= 1'b0;
        end else if (i_clear) begin
            r_state       <= SEQ_IDLE;
            r_bottle_cnt  <= 4'd0;
            r_dozen_cnt   <= 4'd0;
            r_dozen_pulse <= 1'b0;
            r_overrun     <= 1'b0;
            r_pending     <= 1'b0;
            r_prev_done   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_bottle_cnt  <= w_bottle_nxt;
            r_dozen_cnt   <= w_dozen_nxt;
            r_dozen_pulse <= w_pulse_nxt;
            r_overrun     <= w_overrun_nxt;
            r_pending     <= w_pending_nxt;
            r_prev_done   <= i_bottle_done;
        end
    end

    assign o_bottle_cnt  = r_bottle_cnt;
    assign o_dozen_cnt   = r_dozen_cnt;
    assign o_dozen_pulse = r_dozen_pulse;
    assign o_busy        = w_busy;
    assign o_overrun     = r_overrun;
    assign o_full        = w_full;

endmodule

// File: tb/tb_bottle_dozen_sequencer.sv
// Self-checking bench for bottle_dozen_sequencer: directed scenarios plus
// randomized stimulus compared each cycle against a job-based reference model.
module tb_bottle_dozen_sequencer;

    localparam int BATCH = 12;
    localparam int DMAX  = 9;

    logic       i_clk;
    logic       i_reset;
    logic       i_bottle_done;
    logic       i_clear;
    logic [3:0] o_bottle_cnt;
    logic [3:0] o_dozen_cnt;
    logic       o_dozen_pulse;
    logic       o_busy;
    logic       o_overrun;
    logic       o_full;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model: bottles, dozens, queued events and the remaining
    // adder work for the event in progress (0 none, 1 bottle pass, 2 dozen pass).
    int m_b, m_d, m_pend, m_work;
    bit m_pulse, m_ovr, m_prev;

    bottle_dozen_sequencer dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_bottle_done (i_bottle_done),
        .i_clear       (i_clear),
        .o_bottle_cnt  (o_bottle_cnt),
        .o_dozen_cnt   (o_dozen_cnt),
        .o_dozen_pulse (o_dozen_pulse),
        .o_busy        (o_busy),
        .o_overrun     (o_overrun),
        .o_full        (o_full)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic model_reset();
        m_b = 0; m_d = 0; m_pend = 0; m_work = 0;
        m_pulse = 1'b0; m_ovr = 1'b0; m_prev = 1'b0;
    endtask

    task automatic model_edge(input bit d, input bit c);
        bit evt;
        if (c) begin
            model_reset();
        end else begin
            evt     = d && !m_prev;
            m_prev  = d;
            m_pulse = 1'b0;
            if (m_work == 1) begin
                if (evt) begin
                    if (m_pend == 1) m_ovr = 1'b1;
                    else m_pend = 1;
                end
                if (m_b + 1 == BATCH || m_b + 1 > 15) begin
                    m_b = 0; m_work = 2;
                end else begin
                    m_b = m_b + 1; m_work = 0;
                end
            end else if (m_work == 2) begin
                if (evt) begin
                    if (m_pend == 1) m_ovr = 1'b1;
                    else m_pend = 1;
                end
`ifdef SEQ_DOZEN_SAT_EN
                if (m_d == DMAX) m_ovr = 1'b1;
                else begin m_d = m_d + 1; m_pulse = 1'b1; end
`else
                m_d = (m_d == DMAX) ? 0 : (m_d + 1) % 16;
                m_pulse = 1'b1;
`endif
                m_work = 0;
            end else if (evt || m_pend == 1) begin
                m_pend = (evt && m_pend == 1) ? 1 : 0;
                m_work = 1;
            end
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge i_clk) begin
        if (chk_en) begin
            total++;
            if ({o_bottle_cnt, o_dozen_cnt, o_dozen_pulse, o_busy, o_overrun, o_full} !==
                {4'(m_b), 4'(m_d), m_pulse, (m_work != 0), m_ovr, (m_d == DMAX)}) begin
                bad++;
                $display("FAIL monitor t=%0t got b=%0d d=%0d p=%0b busy=%0b ovr=%0b full=%0b want b=%0d d=%0d p=%0b busy=%0b ovr=%0b full=%0b",
                         $time, o_bottle_cnt, o_dozen_cnt, o_dozen_pulse, o_busy, o_overrun, o_full,
                         m_b, m_d, m_pulse, (m_work != 0), m_ovr, (m_d == DMAX));
            end
        end
    end

    task automatic step(input bit d, input bit c);
        i_bottle_done = d;
        i_clear       = c;
        @(posedge i_clk);
        model_edge(d, c);
        #1;
    endtask

    task automatic pulses(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            step(1'b1, 1'b0);
            for (int g = 1; g < gap; g++) step(1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_bottle_done = 1'b0; i_clear = 1'b0;
        #12;
        total++;
        if ({o_bottle_cnt, o_dozen_cnt, o_dozen_pulse, o_busy, o_overrun, o_full} !== 12'h000) begin
            bad++;
            $display("FAIL reset_state got b=%0d d=%0d p=%0b busy=%0b ovr=%0b full=%0b want all zero",
                     o_bottle_cnt, o_dozen_cnt, o_dozen_pulse, o_busy, o_overrun, o_full);
        end
        i_reset = 1'b0;
        model_reset();
        chk_en = 1'b1;
    endtask

    task automatic test_three_pulses();
        int busy_cycles = 0;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0);
            if (o_busy) busy_cycles++;
            for (int g = 0; g < 3; g++) begin
                step(1'b0, 1'b0);
                if (o_busy) busy_cycles++;
            end
        end
        total++;
        if (o_bottle_cnt !== 4'd3 || o_dozen_cnt !== 4'd0 || o_overrun !== 1'b0) begin
            bad++;
            $display("FAIL three_pulses got b=%0d d=%0d ovr=%0b want 3 0 0", o_bottle_cnt, o_dozen_cnt, o_overrun);
        end
        total++;
        if (busy_cycles != 3) begin
            bad++;
            $display("FAIL three_busy got %0d busy cycles want 3", busy_cycles);
        end
    endtask

    task automatic test_dozen();
        step(1'b0, 1'b1);
        pulses(BATCH - 1, 4);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        total++;
        if (o_bottle_cnt !== 4'd0 || o_dozen_cnt !== 4'd0 || o_dozen_pulse !== 1'b0) begin
            bad++;
            $display("FAIL dozen_n2 got b=%0d d=%0d p=%0b want 0 0 0", o_bottle_cnt, o_dozen_cnt, o_dozen_pulse);
        end
        step(1'b0, 1'b0);
        total++;
        if (o_dozen_cnt !== 4'd1 || o_dozen_pulse !== 1'b1) begin
            bad++;
            $display("FAIL dozen_n3 got d=%0d p=%0b want 1 1", o_dozen_cnt, o_dozen_pulse);
        end
        step(1'b0, 1'b0);
        total++;
        if (o_dozen_pulse !== 1'b0 || o_dozen_cnt !== 4'd1) begin
            bad++;
            $display("FAIL dozen_n4 got d=%0d p=%0b want 1 0", o_dozen_cnt, o_dozen_pulse);
        end
    endtask

    task automatic test_reset_mid();
        pulses(BATCH - 1, 4);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        total++;
        if (o_busy !== 1'b1 || o_dozen_cnt !== 4'd1) begin
            bad++;
            $display("FAIL pre_reset got busy=%0b d=%0d want 1 1", o_busy, o_dozen_cnt);
        end
        chk_en = 1'b0;
        #2 i_reset = 1'b1;
        #1;
        total++;
        if ({o_bottle_cnt, o_dozen_cnt, o_dozen_pulse, o_busy, o_overrun} !== 11'h000) begin
            bad++;
            $display("FAIL async_reset got b=%0d d=%0d p=%0b busy=%0b ovr=%0b want all zero",
                     o_bottle_cnt, o_dozen_cnt, o_dozen_pulse, o_busy, o_overrun);
        end
        @(posedge i_clk);
        #2 i_reset = 1'b0;
        model_reset();
        chk_en = 1'b1;
    endtask

    task automatic test_pending();
        pulses(BATCH - 1, 4);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        total++;
        if (o_busy !== 1'b1) begin
            bad++;
            $display("FAIL pending_start got busy=%0b want 1", o_busy);
        end
        step(1'b0, 1'b0);
        total++;
        if (o_bottle_cnt !== 4'd1 || o_dozen_cnt !== 4'd1 || o_overrun !== 1'b0) begin
            bad++;
            $display("FAIL pending_used got b=%0d d=%0d ovr=%0b want 1 1 0", o_bottle_cnt, o_dozen_cnt, o_overrun);
        end
    endtask

    task automatic test_hold();
        step(1'b0, 1'b1);
        for (int k = 0; k < 20; k++) step(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
        total++;
        if (o_bottle_cnt !== 4'd1) begin
            bad++;
            $display("FAIL hold_level got b=%0d want 1", o_bottle_cnt);
        end
    endtask

    task automatic test_clear_mid();
        step(1'b0, 1'b1);
        pulses(3, 4);
        step(1'b1, 1'b0);
        total++;
        if (o_busy !== 1'b1 || o_bottle_cnt !== 4'd3) begin
            bad++;
            $display("FAIL pre_clear got busy=%0b b=%0d want 1 3", o_busy, o_bottle_cnt);
        end
        step(1'b0, 1'b1);
        total++;
        if (o_busy !== 1'b0 || o_bottle_cnt !== 4'd0 || o_dozen_cnt !== 4'd0) begin
            bad++;
            $display("FAIL clear_mid got busy=%0b b=%0d d=%0d want 0 0 0", o_busy, o_bottle_cnt, o_dozen_cnt);
        end
    endtask

    task automatic test_wrap();
        int npulse = 0;
        bit saw_full = 1'b0;
        step(1'b0, 1'b1);
        for (int k = 0; k < 120; k++) begin
            step(1'b1, 1'b0);
            for (int g = 0; g < 3; g++) begin
                step(1'b0, 1'b0);
                if (o_dozen_pulse) npulse++;
                if (o_full) saw_full = 1'b1;
            end
        end
`ifdef SEQ_DOZEN_SAT_EN
        total++;
        if (o_dozen_cnt !== 4'd9 || npulse != 9 || o_full !== 1'b1 || o_overrun !== 1'b1) begin
            bad++;
            $display("FAIL wrap_sat got d=%0d pulses=%0d full=%0b ovr=%0b want 9 9 1 1", o_dozen_cnt, npulse, o_full, o_overrun);
        end
`else
        total++;
        if (o_dozen_cnt !== 4'd0 || npulse != 10 || !saw_full || o_full !== 1'b0 || o_overrun !== 1'b0) begin
            bad++;
            $display("FAIL wrap got d=%0d pulses=%0d saw_full=%0b full=%0b ovr=%0b want 0 10 1 0 0",
                     o_dozen_cnt, npulse, saw_full, o_full, o_overrun);
        end
`endif
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_three_pulses();
        test_dozen();
        test_reset_mid();
        test_pending();
        test_hold();
        test_clear_mid();
        test_wrap();
        test_random();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
